// File: rtl/riscv_peripheral_pkg.sv
// Shared types and constants for the board-input peripherals.
// Debounce FSM state encoding and default filter length.
package riscv_peripheral_pkg;

    typedef enum logic {
        STABLE   = 1'b0,
        COUNTING = 1'b1
    } debounce_state_e;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;

endpackage

// File: rtl/riscv_debounce_channel.sv
// One input channel: synchroniser, debounce FSM and edge pulses.
// Level, rise and fall all update on the same clock edge.
module riscv_debounce_channel
    import riscv_peripheral_pkg::*;
#(
    parameter int   SYNC_STAGES     = 2,
    parameter int   DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter logic RESET_VAL       = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    debounce_state_e        state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   level_d, rise_d, fall_d;

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= {SYNC_STAGES{RESET_VAL}};
            state_q <= STABLE;
            cnt_q   <= '0;
            level   <= RESET_VAL;
            rise    <= 1'b0;
            fall    <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], pin};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level   <= level_d;
            rise    <= rise_d;
            fall    <= fall_d;
        end
    end

    // A new level is accepted only after DEBOUNCE_CYCLES disagreeing samples
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        unique case (state_q)
            STABLE: begin
                if (s != level) begin
                    state_d = COUNTING;
                    cnt_d   = CW'(1);
                end else begin
                    cnt_d = '0;
                end
            end
            COUNTING: begin
                if (s == level) begin
                    state_d = STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE;
                    cnt_d   = '0;
                    level_d = s;
                    rise_d  = s;
                    fall_d  = ~s;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        endcase
    end

endmodule

// File: rtl/riscv_input_bank.sv
// N-channel debounced input bank with sticky edge flags and one
// level interrupt towards the core.
module riscv_input_bank
    import riscv_peripheral_pkg::*;
#(
    parameter int                NUM_CH          = 16,
    parameter int                SYNC_STAGES     = 2,
    parameter int                DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter logic [NUM_CH-1:0] RESET_LEVEL     = '0
) (
    input  logic              i_riscv_inbank_clk,
    input  logic              i_riscv_inbank_rst_n,
    input  logic [NUM_CH-1:0] i_riscv_inbank_pins,
    input  logic [NUM_CH-1:0] i_riscv_inbank_rise_en,
    input  logic [NUM_CH-1:0] i_riscv_inbank_fall_en,
    input  logic [NUM_CH-1:0] i_riscv_inbank_irq_en,
    input  logic [NUM_CH-1:0] i_riscv_inbank_clr,
    output logic [NUM_CH-1:0] o_riscv_inbank_level,
    output logic [NUM_CH-1:0] o_riscv_inbank_rise,
    output logic [NUM_CH-1:0] o_riscv_inbank_fall,
    output logic [NUM_CH-1:0] o_riscv_inbank_pending,
    output logic              o_riscv_inbank_irq
);

    logic [NUM_CH-1:0] set_ev;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        riscv_debounce_channel #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_VAL       (RESET_LEVEL[i])
        ) u_ch (
            .clk   (i_riscv_inbank_clk),
            .rst_n (i_riscv_inbank_rst_n),
            .pin   (i_riscv_inbank_pins[i]),
            .level (o_riscv_inbank_level[i]),
            .rise  (o_riscv_inbank_rise[i]),
            .fall  (o_riscv_inbank_fall[i])
        );
    end

    assign set_ev = (o_riscv_inbank_rise & i_riscv_inbank_rise_en)
                  | (o_riscv_inbank_fall & i_riscv_inbank_fall_en);

    // Set has priority over clear so an event coinciding with a clear survives
    always_ff @(posedge i_riscv_inbank_clk or negedge i_riscv_inbank_rst_n) begin
        if (!i_riscv_inbank_rst_n) begin
            o_riscv_inbank_pending <= '0;
            o_riscv_inbank_irq     <= 1'b0;
        end else begin
            o_riscv_inbank_pending <= (o_riscv_inbank_pending & ~i_riscv_inbank_clr)
                                    | set_ev;
            o_riscv_inbank_irq     <= |(o_riscv_inbank_pending & i_riscv_inbank_irq_en);
        end
    end

endmodule

// File: tb/tb_riscv_input_bank.sv
// Self-checking bench for riscv_input_bank: directed scenarios plus
// randomized pins/enables against a sample-history reference model.
module tb_riscv_input_bank;

    localparam int NCH = 4;
    localparam int SYN = 2;
    localparam int DEB = 4;
    localparam logic [NCH-1:0] RST_LVL = 4'h0;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [NCH-1:0] pins, rise_en, fall_en, irq_en, clr;
    logic [NCH-1:0] level, rise, fall, pending;
    logic           irq;

    int errors = 0;
    int checks = 0;
    bit chk_on = 1'b0;

    logic [NCH-1:0] m_lvl, m_rise, m_fall, m_pend;
    logic           m_irq;
    logic [NCH-1:0] hist[$];
    int             run[NCH];
    logic [NCH-1:0] ms, nl, nr, nf;

    always #5 clk = ~clk;

    riscv_input_bank #(
        .NUM_CH          (NCH),
        .SYNC_STAGES     (SYN),
        .DEBOUNCE_CYCLES (DEB),
        .RESET_LEVEL     (RST_LVL)
    ) dut (
        .i_riscv_inbank_clk     (clk),
        .i_riscv_inbank_rst_n   (rst_n),
        .i_riscv_inbank_pins    (pins),
        .i_riscv_inbank_rise_en (rise_en),
        .i_riscv_inbank_fall_en (fall_en),
        .i_riscv_inbank_irq_en  (irq_en),
        .i_riscv_inbank_clr     (clr),
        .o_riscv_inbank_level   (level),
        .o_riscv_inbank_rise    (rise),
        .o_riscv_inbank_fall    (fall),
        .o_riscv_inbank_pending (pending),
        .o_riscv_inbank_irq     (irq)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: a pin sample reaches the filter SYN edges later; the level
    // flips once DEB consecutive filtered samples disagree with it.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_lvl  = RST_LVL;
            m_rise = '0;
            m_fall = '0;
            m_pend = '0;
            m_irq  = 1'b0;
            hist   = {};
            for (int k = 0; k < SYN; k++) hist.push_back(RST_LVL);
            for (int i = 0; i < NCH; i++) run[i] = 0;
        end else begin
            ms = hist.pop_front();
            hist.push_back(pins);
            nl = m_lvl;
            nr = '0;
            nf = '0;
            for (int i = 0; i < NCH; i++) begin
                if (ms[i] != m_lvl[i]) begin
                    run[i]++;
                    if (run[i] == DEB) begin
                        nl[i]  = ms[i];
                        nr[i]  = ms[i];
                        nf[i]  = ~ms[i];
                        run[i] = 0;
                    end
                end else begin
                    run[i] = 0;
                end
            end
            m_irq  = |(m_pend & irq_en);
            m_pend = (m_pend & ~clr) | (m_rise & rise_en) | (m_fall & fall_en);
            m_rise = nr;
            m_fall = nf;
            m_lvl  = nl;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("level", 32'(level), 32'(m_lvl));
            chk("rise", 32'(rise), 32'(m_rise));
            chk("fall", 32'(fall), 32'(m_fall));
            chk("pending", 32'(pending), 32'(m_pend));
            chk("irq", 32'(irq), 32'(m_irq));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        bit seen;
        pins = 4'hF; rise_en = '0; fall_en = '0; irq_en = '0; clr = '0;
        rst_n = 1'b0;
        cyc(3);
        chk("rst_level", 32'(level), 32'h0);
        chk("rst_rise", 32'(rise), 32'h0);
        chk("rst_pend", 32'(pending), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        rst_n = 1'b1;
        chk_on = 1'b1;

        cyc(5);
        chk("sc1_pre_level", 32'(level), 32'h0);
        cyc(1);
        chk("sc1_level", 32'(level), 32'hF);
        chk("sc1_rise", 32'(rise), 32'hF);
        cyc(1);
        chk("sc1_rise_done", 32'(rise), 32'h0);

        pins = 4'hE; rise_en = 4'h1;
        cyc(8);
        chk("sc2_low", 32'(level), 32'hE);
        pins = 4'hF; irq_en = 4'h1;
        cyc(6);
        chk("sc2_rise0", 32'(rise), 32'h1);
        cyc(1);
        chk("sc2_pend", 32'(pending), 32'h1);
        chk("sc2_irq_lag", 32'(irq), 32'h0);
        cyc(1);
        chk("sc2_irq", 32'(irq), 32'h1);

        pins = 4'hD;
        cyc(8);
        pins = 4'hF;
        cyc(3);
        pins = 4'hD;
        cyc(10);
        chk("sc3_level", 32'(level), 32'hD);
        chk("sc3_pend", 32'(pending), 32'h1);

        pins = 4'hC;
        cyc(8);
        pins = 4'hD;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            cyc(1);
            if (m_rise[0]) seen = 1'b1;
        end
        chk("sc4_rise_seen", 32'(seen), 32'h1);
        clr = 4'h1;
        cyc(1);
        clr = 4'h0;
        chk("sc4_set_wins", 32'(pending), 32'h1);
        cyc(2);
        clr = 4'h1;
        cyc(1);
        clr = 4'h0;
        chk("sc4_cleared", 32'(pending), 32'h0);
        chk("sc4_irq_hold", 32'(irq), 32'h1);
        cyc(1);
        chk("sc4_irq_drop", 32'(irq), 32'h0);

        rise_en = 4'h0; fall_en = 4'h4; irq_en = 4'h0;
        pins = 4'h9;
        cyc(6);
        chk("sc5_fall2", 32'(fall), 32'h4);
        cyc(1);
        chk("sc5_pend", 32'(pending), 32'h4);
        cyc(2);
        chk("sc5_irq_masked", 32'(irq), 32'h0);

        pins = 4'h1;
        cyc(3);
        #2 rst_n = 1'b0;
        #1 chk("sc6_async_level", 32'(level), 32'h0);
        chk("sc6_async_pend", 32'(pending), 32'h0);
        cyc(2);
        rst_n = 1'b1;
        cyc(12);
        chk("sc6_level", 32'(level), 32'h1);

        for (int blk = 0; blk < 40; blk++) begin
            rise_en = NCH'($urandom);
            fall_en = NCH'($urandom);
            irq_en  = NCH'($urandom);
            for (int c = 0; c < 12; c++) begin
                for (int i = 0; i < NCH; i++)
                    if ($urandom_range(0, 5) == 0) pins[i] = ~pins[i];
                clr = ($urandom_range(0, 3) == 0) ? NCH'($urandom) : '0;
                cyc(1);
            end
        end
        clr = '0;
        cyc(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
